fisr_newton_mult: RTL and testbench
===================================

FISR_NEWTON_MULT -- requirements
Module: fisr_newton_mult

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: ce_in  input  1  input-valid strobe from the upstream 1.5-minus stage; one operand pair per cycle while high.
REQ-004 SHALL have port: NumCorr  input  32  correction factor (1.5 - 0.5*x*y^2), IEEE-754 single.
REQ-005 SHALL have port: Init  input  32  current estimate y, IEEE-754 single, time-aligned with NumCorr.
REQ-006 SHALL have port: Result  output  32  y_new = Init * NumCorr, IEEE-754 single, registered.
REQ-007 SHALL have port: ce_out  output  1  Result-valid strobe, registered.
REQ-008 SHALL have port: res_count  output  16  count of results delivered since reset, registered.

Function
REQ-009 SHALL be a free-running 3-stage pipeline with no stall: Result/ce_out reflect the pair sampled with ce_in exactly 3 cycles earlier.
REQ-010 SHALL sample operands every cycle; ce_in only travels through a 3-bit valid shift chain to ce_out.
REQ-011 Stage 1 SHALL register: sign = NumCorr[31] XOR Init[31]; mantissas {1,m[22:0]} (24 bits each); exp_sum = eA + eB - 127 as 10-bit signed; special-case flags.
REQ-012 Stage 2 SHALL register the full 48-bit unsigned product of the two 24-bit mantissas, carrying sign, exp_sum, flags forward.
REQ-013 Stage 3 normalization: if product[47]=1 -> mantissa = product[46:24], exp = exp_sum + 1; else mantissa = product[45:23], exp = exp_sum.
REQ-014 Rounding SHALL be truncation (discard lower product bits); no round-to-nearest.
REQ-015 Input with exponent 0 (zero or denormal) SHALL be treated as zero (flush-to-zero).
REQ-016 Zero operand with finite other operand SHALL give {sign, 31'b0}.
REQ-017 Either operand exponent 255 with other operand zero SHALL give 0x7FC00000 (quiet NaN).
REQ-018 Either operand NaN (exp 255, mantissa nonzero) SHALL give 0x7FC00000; inf times nonzero finite/inf SHALL give {sign, 8'hFF, 23'b0}.
REQ-019 Final exp >= 255 SHALL saturate to {sign, 8'hFF, 23'b0}; final exp <= 0 SHALL flush to {sign, 31'b0}.
REQ-020 Special-case results SHALL override arithmetic results, priority: NaN > inf > zero/underflow > normal.
REQ-021 res_count SHALL increment by 1 in the cycle ce_out is asserted and wrap from 0xFFFF to 0x0000.
REQ-022 Result SHALL update every cycle regardless of ce_out; consumers qualify with ce_out.
REQ-023 Back-to-back ce_in pulses SHALL produce back-to-back ce_out pulses with independent results, no bubbles.

Reset
REQ-024 On rst=1 at a clock edge: Result=0x00000000, ce_out=0, res_count=0, all pipeline valid bits=0.
REQ-025 Reset mid-operation SHALL discard all in-flight pairs; no ce_out pulse for pairs sampled before or during reset.
REQ-026 First valid output after reset release SHALL occur 3 cycles after the first cycle with rst=0 and ce_in=1.
REQ-027 Pipeline data registers other than Result need no reset value; valid bits and res_count do.

Verification
REQ-028 Basic: NumCorr=0x3FC00000 (1.5), Init=0x3F800000 (1.0), ce_in one cycle -> 3 cycles later Result=0x3FC00000, ce_out=1 for 1 cycle, res_count=1.
REQ-029 Normalization: 0x3FC00000 * 0x3FC00000 -> 0x40100000 (2.25); 0x3F000000 * 0x40000000 -> 0x3F800000.
REQ-030 Specials: 0x00000000 * 0x3FC00000 -> 0x00000000; 0x7F800000 * 0x00000000 -> 0x7FC00000; 0xBF800000 * 0x3F800000 -> 0xBF800000.
REQ-031 Range: 0x7F000000 * 0x7F000000 -> 0x7F800000; 0x00800000 * 0x00800000 -> 0x00000000.
REQ-032 Streaming/reset: 5 consecutive ce_in pairs -> 5 consecutive ce_out cycles in order; assert rst after 2nd output -> no further ce_out, res_count=0; preload res_count path with 65536 results -> wraps to 0.

Source files
------------

// File: rtl/fisr_newton_mult.sv
// Newton-step multiplier for a fast inverse square root: y_new = Init * NumCorr.
// Free-running 3-stage single-precision multiplier; truncating, flush-to-zero.
module fisr_newton_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_in,
  input  logic [31:0] NumCorr,
  input  logic [31:0] Init,
  output logic [31:0] Result,
  output logic        ce_out,
  output logic [15:0] res_count
);

  // Valid protocol: ce_in marks the operand pair on NumCorr/Init as valid in
  // that cycle; there is no ready, the pipeline never stalls. ce_out marks
  // Result valid exactly three cycles later. Result changes every cycle, so
  // consumers must qualify it with ce_out.

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign ea = NumCorr[30:23];
  assign eb = Init[30:23];
  assign fa = NumCorr[22:0];
  assign fb = Init[22:0];

  // Exponent 0 covers both zero and denormals; both are treated as zero.
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'h0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'h0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'h0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'h0);

  logic               s1_sign_d, s1_nan_d, s1_inf_d, s1_zero_d;
  logic [23:0]        s1_ma_d, s1_mb_d;
  logic signed [9:0]  s1_exp_d;

  assign s1_sign_d = NumCorr[31] ^ Init[31];
  assign s1_ma_d   = {1'b1, fa};
  assign s1_mb_d   = {1'b1, fb};
  assign s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
  assign s1_nan_d  = a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero));
  assign s1_inf_d  = a_inf || b_inf;
  assign s1_zero_d = a_zero || b_zero;

  logic               s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic [23:0]        s1_ma_q, s1_mb_q;
  logic signed [9:0]  s1_exp_q;

  logic               s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
  logic [47:0]        s2_prod_q;
  logic signed [9:0]  s2_exp_q;

  // Data path registers carry no reset; only valid bits, count and Result do.
  always_ff @(posedge clk) begin
    s1_sign_q <= s1_sign_d;
    s1_nan_q  <= s1_nan_d;
    s1_inf_q  <= s1_inf_d;
    s1_zero_q <= s1_zero_d;
    s1_ma_q   <= s1_ma_d;
    s1_mb_q   <= s1_mb_d;
    s1_exp_q  <= s1_exp_d;

    s2_sign_q <= s1_sign_q;
    s2_nan_q  <= s1_nan_q;
    s2_inf_q  <= s1_inf_q;
    s2_zero_q <= s1_zero_q;
    s2_exp_q  <= s1_exp_q;
    s2_prod_q <= s1_ma_q * s1_mb_q;
  end

  logic signed [9:0] s3_exp;
  logic [22:0]       s3_mant;
  logic [31:0]       result_d;

  // Product of two 1.x mantissas lies in [1,4); bit 47 set means [2,4).
  always_comb begin
    s3_mant = 23'(s2_prod_q >> (s2_prod_q[47] ? 6'd24 : 6'd23));
    s3_exp  = s2_prod_q[47] ? (s2_exp_q + 10'sd1) : s2_exp_q;
    result_d = {s2_sign_q, s3_exp[7:0], s3_mant};
    if (s2_nan_q) begin
      result_d = 32'h7FC0_0000;
    end else if (s2_inf_q) begin
      result_d = {s2_sign_q, 8'hFF, 23'h0};
    end else if (s2_zero_q) begin
      result_d = {s2_sign_q, 31'h0};
    end else if (s3_exp >= 10'sd255) begin
      result_d = {s2_sign_q, 8'hFF, 23'h0};
    end else if (s3_exp <= 10'sd0) begin
      result_d = {s2_sign_q, 31'h0};
    end
  end

  logic [2:0]  valid_q, valid_d;
  logic [31:0] result_q;
  logic [15:0] res_count_q, res_count_d;

  assign valid_d     = {valid_q[1:0], ce_in};
  // Count advances together with ce_out so res_count already includes it.
  assign res_count_d = valid_q[1] ? (res_count_q + 16'd1) : res_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 3'b000;
      result_q    <= 32'h0;
      res_count_q <= 16'h0;
    end else begin
      valid_q     <= valid_d;
      result_q    <= result_d;
      res_count_q <= res_count_d;
    end
  end

  assign Result    = result_q;
  assign ce_out    = valid_q[2];
  assign res_count = res_count_q;

endmodule

// File: tb/tb_fisr_newton_mult.sv
// Self-checking bench for fisr_newton_mult: directed vectors, randomized
// operands against a field-level reference model, streaming, reset and wrap.
module tb_fisr_newton_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_in;
  logic [31:0] num_corr;
  logic [31:0] init_v;
  logic [31:0] result;
  logic        ce_out;
  logic [15:0] res_count;

  int          cmp_count = 0;
  int          err_count = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt;

  fisr_newton_mult dut (
    .clk      (clk),
    .rst      (rst),
    .ce_in    (ce_in),
    .NumCorr  (num_corr),
    .Init     (init_v),
    .Result   (result),
    .ce_out   (ce_out),
    .res_count(res_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    ce_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 16'h0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    int              ea, eb, e;
    longint unsigned ma, mb, p, frac;
    logic            s;
    logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
    if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {s, 31'h0};
    ma = 64'(a[22:0]) + 64'h80_0000;
    mb = 64'(b[22:0]) + 64'h80_0000;
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= 64'h8000_0000_0000) begin
      e    = e + 1;
      frac = (p >> 24) & 64'h7F_FFFF;
    end else begin
      frac = (p >> 23) & 64'h7F_FFFF;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), 23'(frac)};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    int          k;
    k = $urandom_range(0, 11);
    f = 23'($urandom);
    s = 1'($urandom);
    case (k)
      0:       e = 8'h00;
      1:       begin e = 8'hFF; f = 23'h0; end
      2:       begin e = 8'hFF; f = f | 23'h1; end
      3:       e = 8'($urandom_range(190, 254));
      4:       e = 8'($urandom_range(1, 64));
      5:       begin e = 8'h00; f = 23'h0; end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {s, e, f};
  endfunction

  // ---------------- driver ----------------
  task automatic step_drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e);
    @(posedge clk); #1;
    ce_in    = v;
    num_corr = a;
    init_v   = b;
    if (v) exp_q.push_back(e);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    ce_in = 1'b1;
    num_corr = 32'h3FC0_0000;
    init_v = 32'h3F80_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_count++;
    if (result !== 32'h0) begin
      err_count++; $display("FAIL reset_result: got %h expected 00000000", result);
    end
    cmp_count++;
    if (ce_out !== 1'b0) begin
      err_count++; $display("FAIL reset_ce_out: got %b expected 0", ce_out);
    end
    cmp_count++;
    if (res_count !== 16'h0) begin
      err_count++; $display("FAIL reset_res_count: got %h expected 0000", res_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ce_in = 1'b0;
    exp_q.delete();
    exp_cnt = 16'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cmp_count++;
      if (ce_out !== 1'b0) begin
        err_count++; $display("FAIL reset_discard: got ce_out %b expected 0 at cycle %0d", ce_out, c);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] e;
    do_reset();
    step_drive(1'b1, 32'h3FC0_0000, 32'h3F80_0000, 32'h3FC0_0000);
    for (int c = 1; c <= 4; c++) begin
      step_drive(1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      cmp_count++;
      if (ce_out !== (c == 3)) begin
        err_count++; $display("FAIL basic_latency: cycle %0d got ce_out %b expected %b", c, ce_out, (c == 3));
      end
      if (c == 3) begin
        e = exp_q.pop_front();
        cmp_count++;
        if (result !== e) begin
          err_count++; $display("FAIL basic_result: got %h expected %h", result, e);
        end
      end
      if (c >= 3) begin
        cmp_count++;
        if (res_count !== 16'd1) begin
          err_count++; $display("FAIL basic_res_count: cycle %0d got %0d expected 1", c, res_count);
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[8];
    logic [31:0] vb[8];
    logic [31:0] ve[8];
    logic [31:0] e;
    va = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h3F00_0000, 32'h0000_0000,
           32'h7F80_0000, 32'hBF80_0000, 32'h7F00_0000, 32'h0080_0000};
    vb = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4000_0000, 32'h3FC0_0000,
           32'h0000_0000, 32'h3F80_0000, 32'h7F00_0000, 32'h0080_0000};
    ve = '{32'h3FC0_0000, 32'h4010_0000, 32'h3F80_0000, 32'h0000_0000,
           32'h7FC0_0000, 32'hBF80_0000, 32'h7F80_0000, 32'h0000_0000};
    do_reset();
    for (int i = 0; i < 8 + 6; i++) begin
      if (i < 8) step_drive(1'b1, va[i], vb[i], ve[i]);
      else       step_drive(1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      if (ce_out === 1'b1) begin
        cmp_count++;
        if (exp_q.size() == 0) begin
          err_count++; $display("FAIL directed_extra: unexpected output %h", result);
        end else begin
          e = exp_q.pop_front();
          exp_cnt = exp_cnt + 16'd1;
          if (result !== e) begin
            err_count++; $display("FAIL directed_result: got %h expected %h", result, e);
          end
          cmp_count++;
          if (res_count !== exp_cnt) begin
            err_count++; $display("FAIL directed_res_count: got %0d expected %0d", res_count, exp_cnt);
          end
        end
      end
    end
    cmp_count++;
    if (exp_q.size() != 0) begin
      err_count++; $display("FAIL directed_missing: got %0d outputs pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, e;
    logic        v;
    do_reset();
    for (int i = 0; i < 400 + 6; i++) begin
      a = rand_operand();
      b = rand_operand();
      v = (i < 400) && ($urandom_range(0, 3) != 0);
      step_drive(v, a, b, model_mul(a, b));
      @(negedge clk);
      if (ce_out === 1'b1) begin
        cmp_count++;
        if (exp_q.size() == 0) begin
          err_count++; $display("FAIL random_extra: unexpected output %h", result);
        end else begin
          e = exp_q.pop_front();
          exp_cnt = exp_cnt + 16'd1;
          if (result !== e) begin
            err_count++; $display("FAIL random_result: got %h expected %h", result, e);
          end
          cmp_count++;
          if (res_count !== exp_cnt) begin
            err_count++; $display("FAIL random_res_count: got %0d expected %0d", res_count, exp_cnt);
          end
        end
      end
    end
    cmp_count++;
    if (exp_q.size() != 0) begin
      err_count++; $display("FAIL random_missing: got %0d outputs pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, e;
    int          n_out;
    logic        started;
    do_reset();
    n_out = 0;
    started = 1'b0;
    for (int i = 0; i < 5 + 6; i++) begin
      a = rand_operand();
      b = rand_operand();
      if (i < 5) step_drive(1'b1, a, b, model_mul(a, b));
      else       step_drive(1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      if (ce_out === 1'b1) begin
        started = 1'b1;
        n_out++;
        e = exp_q.pop_front();
        cmp_count++;
        if (result !== e) begin
          err_count++; $display("FAIL b2b_result: got %h expected %h", result, e);
        end
      end else if (started && n_out < 5) begin
        cmp_count++;
        err_count++; $display("FAIL b2b_bubble: got gap after %0d outputs expected 5 in a row", n_out);
        started = 1'b0;
      end
    end
    cmp_count++;
    if (n_out != 5) begin
      err_count++; $display("FAIL b2b_count: got %0d outputs expected 5", n_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b, e;
    int          n_out;
    logic        reset_done;
    do_reset();
    n_out = 0;
    reset_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      a = rand_operand();
      b = rand_operand();
      if (!reset_done && i < 5) step_drive(1'b1, a, b, model_mul(a, b));
      else                      step_drive(1'b0, 32'h0, 32'h0, 32'h0);
      if (reset_done) rst = 1'b0;
      @(negedge clk);
      if (reset_done) begin
        cmp_count++;
        if (ce_out !== 1'b0) begin
          err_count++; $display("FAIL midreset_ce_out: got %b expected 0 at cycle %0d", ce_out, i);
        end
        cmp_count++;
        if (res_count !== 16'h0) begin
          err_count++; $display("FAIL midreset_res_count: got %0d expected 0", res_count);
        end
      end else if (ce_out === 1'b1) begin
        n_out++;
        e = exp_q.pop_front();
        cmp_count++;
        if (result !== e) begin
          err_count++; $display("FAIL midreset_result: got %h expected %h", result, e);
        end
        if (n_out == 2) begin
          rst = 1'b1;
          ce_in = 1'b0;
          exp_q.delete();
          exp_cnt = 16'h0;
          reset_done = 1'b1;
        end
      end
    end
    cmp_count++;
    if (!reset_done) begin
      err_count++; $display("FAIL midreset_outputs: got %0d outputs expected at least 2", n_out);
    end
  endtask

  task automatic test_count_wrap();
    int n_out;
    do_reset();
    n_out = 0;
    for (int i = 0; i < 65536 + 6; i++) begin
      if (i < 65536) begin
        @(posedge clk); #1;
        ce_in = 1'b1;
        num_corr = 32'h3F80_0000;
        init_v = 32'h3F80_0000;
      end else begin
        @(posedge clk); #1;
        ce_in = 1'b0;
      end
      @(negedge clk);
      if (ce_out === 1'b1) begin
        n_out++;
        exp_cnt = exp_cnt + 16'd1;
        if (n_out == 1 || n_out == 65535 || n_out == 65536) begin
          cmp_count++;
          if (res_count !== exp_cnt) begin
            err_count++; $display("FAIL wrap_res_count: after %0d results got %h expected %h", n_out, res_count, exp_cnt);
          end
        end
      end
    end
    cmp_count++;
    if (n_out != 65536) begin
      err_count++; $display("FAIL wrap_outputs: got %0d expected 65536", n_out);
    end
    cmp_count++;
    if (res_count !== 16'h0) begin
      err_count++; $display("FAIL wrap_final: got %h expected 0000", res_count);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1;
    ce_in = 1'b0;
    num_corr = 32'h0;
    init_v = 32'h0;
    exp_cnt = 16'h0;
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
